rocket_ctrl_fsm: RTL and testbench
==================================

Name: rocket_ctrl_fsm

Overview:
Parametrised successor to the player rocket controller. It sequences title → screen clear → homebase draw → command loop, and owns the rocket x-position register. Movement is frame-paced and saturating, and uses an erase/redraw handshake with the VGA datapath. A fire-request handshake is added, with one shot outstanding at a time. It sits between the key/switch inputs and the VGA drawing datapath.

Parameters:
X_W, 8, width of the x-position register
X_MIN, 0, leftmost legal rocket x
X_MAX, 152, rightmost legal rocket x (X_MIN < X_MAX < 2^X_W)
X_START, 76, x loaded on reset and on every new game
STEP, 4, pixels moved per accepted move (1..X_MAX-X_MIN)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  start key, level; press-and-release starts a game
cmd_left  in  1  left key, level, active-high
cmd_right  in  1  right key, level, active-high
cmd_fire  in  1  fire key, level, active-high
frame_tick  in  1  one-cycle pulse per video frame; paces movement
clear_done  in  1  datapath finished the full-screen clear
draw_done  in  1  datapath finished the current homebase/rocket draw or erase
fire_ack  in  1  projectile unit accepted the shot
clear_en  out  1  request full-screen clear
draw_en  out  1  request rocket draw at rocket_x
erase_en  out  1  request rocket erase at rocket_x
base_en  out  1  request homebase draw
fire_req  out  1  shot request, held until acknowledged
rocket_x  out  X_W  current rocket x
idle  out  1  FSM in TITLE or TITLE_WAIT
state_dbg  out  4  encoded current state, for the bench

Behaviour:
- Reset applies when resetn=0 at a clk edge. It sets state to TITLE, rocket_x to X_START, fire_req to 0 and the fire edge register to 0. Reset overrides every other input, including mid-handshake.
- Moore outputs are decoded from the registered state. At reset, clear_en, draw_en, erase_en and base_en are 0 and idle is 1.
- States and transitions:
  - TITLE: go to TITLE_WAIT when start=1.
  - TITLE_WAIT: go to CLEAR when start=0.
  - CLEAR: clear_en=1. Go to BASE when clear_done=1. Also reload rocket_x to X_START on entry.
  - BASE: base_en=1. Go to DRAW when draw_done=1.
  - DRAW: draw_en=1. Go to COMMAND when draw_done=1.
  - COMMAND: waits for frame_tick. On frame_tick, if exactly one of cmd_left/cmd_right is 1 and the move target differs from rocket_x, go to ERASE. Otherwise stay in COMMAND.
  - ERASE: erase_en=1. On draw_done, go to UPDATE.
  - UPDATE: a single cycle. Load rocket_x with the target, then go to DRAW.
- Target computation:
  - Left target = X_MIN if rocket_x < X_MIN+STEP, else rocket_x-STEP.
  - Right target = X_MAX if rocket_x > X_MAX-STEP, else rocket_x+STEP.
  - Compute in X_W+1 bits; no wrap-around is permitted.
  - The direction is latched at the COMMAND→ERASE transition; key changes after that are ignored.
- Both keys held, or neither held, means no move. A key held at the boundary causes no erase/redraw cycle.
- Frame pacing: at most one move per frame_tick. A frame_tick arriving outside COMMAND is dropped.
- Fire handling:
  - A rising edge of cmd_fire (registered previous value) seen in COMMAND, ERASE, UPDATE or DRAW-after-BASE sets fire_req=1, unless fire_req is already 1; in that case the edge is dropped.
  - fire_req clears on the cycle after fire_ack=1.
  - If fire_ack and a new fire edge occur in the same cycle, the ack wins and the edge is dropped.
  - Fire edges in TITLE, TITLE_WAIT, CLEAR or BASE are ignored.
  - fire_req is cleared on entry to CLEAR.
- Done inputs are only sampled in states that wait on them. A stray clear_done or draw_done in any other state has no effect.
- state_dbg encoding: TITLE=0, TITLE_WAIT=1, CLEAR=2, BASE=3, DRAW=4, COMMAND=5, ERASE=6, UPDATE=7.

Test Plan:
- Startup: reset, then start=1 for 3 cycles, then 0. Expect the state path TITLE→TITLE_WAIT→CLEAR. clear_en stays high until clear_done. Then base_en until draw_done, then draw_en until draw_done, then COMMAND with rocket_x=76.
- Move right with saturation: hold cmd_right for 25 frame_ticks, answering each erase/draw with draw_done. rocket_x steps 80, 84 … 152 and stays at 152. No erase_en pulse occurs once rocket_x=152.
- Move left with STEP=5 and X_MIN=0, starting at rocket_x=3: one left tick gives rocket_x=0, with no underflow wrap. The next left tick produces no ERASE.
- Both keys: cmd_left=cmd_right=1 across 5 ticks. State stays COMMAND, rocket_x is unchanged and erase_en=0 throughout.
- Fire handshake: press cmd_fire and hold 10 cycles. fire_req rises once. A second press before fire_ack is dropped. After fire_ack, fire_req is 0 on the next cycle, and a new press sets it again.
- Reset mid-operation: assert resetn=0 while in ERASE with fire_req=1 and rocket_x=100. Next cycle: state=TITLE, rocket_x=76, fire_req=0, all enables 0, idle=1.

Source files
------------

// File: rtl/rocket_ctrl_if.sv
// rocket_ctrl_if: bundle between the rocket controller and the key/VGA side.
//   master : the controller. It takes the keys, frame_tick and the done/ack strobes,
//            and drives the draw requests, fire_req, rocket_x, idle and state_dbg.
//   slave  : the key/datapath side. It drives the inputs and observes the requests.
interface rocket_ctrl_if #(
    parameter int X_W = 8
);
    logic           start;
    logic           cmd_left;
    logic           cmd_right;
    logic           cmd_fire;
    logic           frame_tick;
    logic           clear_done;
    logic           draw_done;
    logic           fire_ack;
    logic           clear_en;
    logic           draw_en;
    logic           erase_en;
    logic           base_en;
    logic           fire_req;
    logic [X_W-1:0] rocket_x;
    logic           idle;
    logic [3:0]     state_dbg;

    modport master (
        input  start, cmd_left, cmd_right, cmd_fire, frame_tick,
               clear_done, draw_done, fire_ack,
        output clear_en, draw_en, erase_en, base_en, fire_req,
               rocket_x, idle, state_dbg
    );

    modport slave (
        output start, cmd_left, cmd_right, cmd_fire, frame_tick,
               clear_done, draw_done, fire_ack,
        input  clear_en, draw_en, erase_en, base_en, fire_req,
               rocket_x, idle, state_dbg
    );
endinterface

// File: rtl/rocket_ctrl_fsm.sv
// rocket_ctrl_fsm: player rocket controller.
// The game runs title -> screen clear -> homebase draw -> command loop.
// The block owns the rocket x register. Moves are frame-paced and saturate
// at X_MIN/X_MAX. Each move runs an erase/redraw handshake with the VGA datapath.
// Only one fire request is outstanding at a time.
// Ports:
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : rocket_ctrl_if master (keys, strobes, draw requests, fire, rocket_x, debug)
module rocket_ctrl_fsm #(
    parameter int X_W     = 8,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 152,
    parameter int X_START = 76,
    parameter int STEP    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    rocket_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        TITLE      = 4'd0,
        TITLE_WAIT = 4'd1,
        CLEAR      = 4'd2,
        BASE       = 4'd3,
        DRAW       = 4'd4,
        COMMAND    = 4'd5,
        ERASE      = 4'd6,
        UPDATE     = 4'd7
    } state_t;

    // The limits are widened by one bit so that x+STEP and x-STEP cannot wrap.
    localparam logic [X_W:0] XMIN_E = (X_W+1)'(X_MIN);
    localparam logic [X_W:0] XMAX_E = (X_W+1)'(X_MAX);
    localparam logic [X_W:0] STEP_E = (X_W+1)'(STEP);

    state_t         state;
    logic [X_W-1:0] x;
    logic           fire_q;
    logic           fire_req;
    logic           dir_right;

    logic [X_W:0]   x_ext, left_tgt, right_tgt, tgt;
    logic           sel_right, one_key, fire_edge, fire_win, clear_entry;

    always_comb begin
        x_ext     = {1'b0, x};
        left_tgt  = (x_ext < XMIN_E + STEP_E) ? XMIN_E : x_ext - STEP_E;
        right_tgt = (x_ext > XMAX_E - STEP_E) ? XMAX_E : x_ext + STEP_E;
        // In COMMAND the live key selects the direction. After that, the
        // direction latched at the COMMAND->ERASE transition is used.
        sel_right = (state == COMMAND) ? bus.cmd_right : dir_right;
        tgt       = sel_right ? right_tgt : left_tgt;
        one_key   = bus.cmd_left ^ bus.cmd_right;
        fire_edge = bus.cmd_fire & ~fire_q;
        fire_win  = (state == DRAW) || (state == COMMAND) ||
                    (state == ERASE) || (state == UPDATE);
        clear_entry = (state == TITLE_WAIT) && !bus.start;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= TITLE;
            x         <= X_W'(X_START);
            fire_q    <= 1'b0;
            fire_req  <= 1'b0;
            dir_right <= 1'b0;
        end else begin
            fire_q <= bus.cmd_fire;
            case (state)
                TITLE:      if (bus.start) state <= TITLE_WAIT;
                TITLE_WAIT: if (!bus.start) begin
                                state <= CLEAR;
                                x     <= X_W'(X_START);
                            end
                CLEAR:      if (bus.clear_done) state <= BASE;
                BASE:       if (bus.draw_done) state <= DRAW;
                DRAW:       if (bus.draw_done) state <= COMMAND;
                COMMAND:    if (bus.frame_tick && one_key && tgt != x_ext) begin
                                state     <= ERASE;
                                dir_right <= bus.cmd_right;
                            end
                ERASE:      if (bus.draw_done) state <= UPDATE;
                UPDATE:     begin
                                x     <= tgt[X_W-1:0];
                                state <= DRAW;
                            end
                default:    state <= TITLE;
            endcase
            // The ack takes priority over a new edge in the same cycle, so
            // that edge is lost.
            if (clear_entry || bus.fire_ack)
                fire_req <= 1'b0;
            else if (fire_edge && fire_win)
                fire_req <= 1'b1;
        end
    end

    assign bus.clear_en  = (state == CLEAR);
    assign bus.base_en   = (state == BASE);
    assign bus.draw_en   = (state == DRAW);
    assign bus.erase_en  = (state == ERASE);
    assign bus.idle      = (state == TITLE) || (state == TITLE_WAIT);
    assign bus.fire_req  = fire_req;
    assign bus.rocket_x  = x;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_rocket_ctrl_fsm.sv
module tb_rocket_ctrl_fsm;
    localparam int XW = 8, XMIN = 0, XMAX = 152, XST = 76, STP = 4;
    localparam int S_TITLE = 0, S_TW = 1, S_CLEAR = 2, S_BASE = 3;
    localparam int S_DRAW = 4, S_CMD = 5, S_ERASE = 6, S_UPD = 7;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rocket_ctrl_if #(.X_W(XW)) bus ();
    rocket_ctrl_if #(.X_W(XW)) bus2 ();

    rocket_ctrl_fsm #(.X_W(XW), .X_MIN(XMIN), .X_MAX(XMAX), .X_START(XST), .STEP(STP))
        dut (.clk(clk), .resetn(resetn), .bus(bus));

    // Second instance: odd step size, starting near the left edge.
    rocket_ctrl_fsm #(.X_W(XW), .X_MIN(0), .X_MAX(152), .X_START(3), .STEP(5))
        dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    int total = 0;
    int bad = 0;

    // Reference model state: the phase the bench expects, x, and the fire request.
    int m_st = S_TITLE;
    int m_x = XST;
    bit m_req = 0;
    bit m_prev = 0;
    bit m_rand = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Clock one cycle of dut. nxt is the phase the bench expects after this edge.
    task automatic step(input int nxt);
        bit ok;
        if (m_rand) begin
            if ($urandom_range(0, 2) == 0) bus.cmd_fire = ~bus.cmd_fire;
            bus.fire_ack   = ($urandom_range(0, 4) == 0);
            bus.clear_done = $urandom_range(0, 1);
        end
        ok = (m_st == S_DRAW) || (m_st == S_CMD) || (m_st == S_ERASE) || (m_st == S_UPD);
        if (!resetn) begin
            m_req = 0; m_prev = 0; m_x = XST;
        end else begin
            if ((m_st == S_TW && nxt == S_CLEAR) || bus.fire_ack) m_req = 0;
            else if (bus.cmd_fire && !m_prev && ok) m_req = 1;
            m_prev = bus.cmd_fire;
        end
        @(posedge clk); #1;
        m_st = nxt;
        chk("state", bus.state_dbg, m_st);
        chk("rocket_x", bus.rocket_x, m_x);
        chk("fire_req", bus.fire_req, m_req);
        chk("clear_en", bus.clear_en, m_st == S_CLEAR);
        chk("base_en", bus.base_en, m_st == S_BASE);
        chk("draw_en", bus.draw_en, m_st == S_DRAW);
        chk("erase_en", bus.erase_en, m_st == S_ERASE);
        chk("idle", bus.idle, m_st == S_TITLE || m_st == S_TW);
    endtask

    task automatic startup();
        bus.start = 1; step(S_TW); step(S_TW); step(S_TW);
        bus.start = 0; m_x = XST; step(S_CLEAR);
        step(S_CLEAR);
        bus.draw_done = 1; step(S_CLEAR); bus.draw_done = 0;   // a stray done is ignored
        bus.clear_done = 1; step(S_BASE); bus.clear_done = 0;
        bus.cmd_fire = 1; step(S_BASE); bus.cmd_fire = 0;       // a fire edge in BASE is ignored
        step(S_BASE);
        bus.draw_done = 1; step(S_DRAW); step(S_CMD); bus.draw_done = 0;
    endtask

    function automatic int target(input int x, input bit right);
        if (right) return (x + STP > XMAX) ? XMAX : x + STP;
        return (x - STP < XMIN) ? XMIN : x - STP;
    endfunction

    task automatic play(input bit l, input bit r, input bit tk);
        int t;
        t = target(m_x, r);
        bus.cmd_left = l; bus.cmd_right = r; bus.frame_tick = tk;
        if (tk && (l ^ r) && t != m_x) begin
            step(S_ERASE);
            bus.frame_tick = 0;
            repeat ($urandom_range(0, 3)) begin
                bus.cmd_left = $urandom_range(0, 1); bus.cmd_right = $urandom_range(0, 1);
                bus.frame_tick = $urandom_range(0, 1);
                step(S_ERASE);
            end
            bus.draw_done = 1; step(S_UPD); bus.draw_done = 0;
            m_x = t; step(S_DRAW);
            repeat ($urandom_range(0, 2)) begin
                bus.frame_tick = $urandom_range(0, 1);
                step(S_DRAW);
            end
            bus.frame_tick = 0;
            bus.draw_done = 1; step(S_CMD); bus.draw_done = 0;
        end else begin
            step(S_CMD);
            bus.frame_tick = 0;
        end
    endtask

    task automatic cyc2();
        @(posedge clk); #1;
    endtask

    task automatic move2(input bit r, input int old_x);
        int t;
        t = r ? ((old_x + 5 > 152) ? 152 : old_x + 5) : ((old_x < 5) ? 0 : old_x - 5);
        bus2.cmd_left = !r; bus2.cmd_right = r; bus2.frame_tick = 1;
        cyc2(); bus2.frame_tick = 0;
        if (t == old_x) begin
            chk("d2_idle_state", bus2.state_dbg, S_CMD);
            chk("d2_idle_erase", bus2.erase_en, 0);
            chk("d2_idle_x", bus2.rocket_x, old_x);
        end else begin
            chk("d2_erase_state", bus2.state_dbg, S_ERASE);
            bus2.draw_done = 1; cyc2(); cyc2();
            chk("d2_draw_state", bus2.state_dbg, S_DRAW);
            chk("d2_x", bus2.rocket_x, t);
            cyc2(); bus2.draw_done = 0;
            chk("d2_cmd_state", bus2.state_dbg, S_CMD);
        end
    endtask

    initial begin
        int x2;
        {bus.start, bus.cmd_left, bus.cmd_right, bus.cmd_fire, bus.frame_tick} = '0;
        {bus.clear_done, bus.draw_done, bus.fire_ack} = '0;
        {bus2.start, bus2.cmd_left, bus2.cmd_right, bus2.cmd_fire, bus2.frame_tick} = '0;
        {bus2.clear_done, bus2.draw_done, bus2.fire_ack} = '0;

        resetn = 0; step(S_TITLE); step(S_TITLE);
        resetn = 1; step(S_TITLE);
        startup();

        // Move to x=100, raise a fire request, enter ERASE, then reset.
        repeat (6) play(0, 1, 1);
        bus.cmd_right = 0; bus.cmd_fire = 0; step(S_CMD);
        bus.cmd_fire = 1; step(S_CMD); bus.cmd_fire = 0;
        bus.cmd_right = 1; bus.frame_tick = 1; step(S_ERASE);
        bus.frame_tick = 0; bus.cmd_right = 0;
        resetn = 0; step(S_TITLE);
        resetn = 1; step(S_TITLE);
        startup();

        // Right saturation: no erase once x reaches 152.
        repeat (25) play(0, 1, 1);
        // Both keys held: no move.
        repeat (5) play(1, 1, 1);
        // Fire handshake.
        bus.cmd_left = 0; bus.cmd_right = 0;
        bus.cmd_fire = 1; repeat (10) step(S_CMD);
        bus.cmd_fire = 0; step(S_CMD);
        bus.cmd_fire = 1; step(S_CMD);          // dropped, a request is outstanding
        bus.cmd_fire = 0; bus.fire_ack = 1; step(S_CMD);
        bus.fire_ack = 0; step(S_CMD);
        bus.cmd_fire = 1; step(S_CMD);          // a new press sets it again
        bus.cmd_fire = 1; bus.fire_ack = 1; step(S_CMD);
        bus.cmd_fire = 0; bus.fire_ack = 0; step(S_CMD);
        // Left all the way to X_MIN.
        repeat (40) play(1, 0, 1);

        // Randomized play with fire, ack and stray strobes.
        m_rand = 1;
        for (int it = 0; it < 300; it++)
            play($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) == 0);
        m_rand = 0;
        bus.fire_ack = 0; bus.clear_done = 0; bus.cmd_fire = 0;
        bus.cmd_left = 0; bus.cmd_right = 0;

        // Second instance: STEP=5, start at 3.
        resetn = 0; cyc2(); cyc2(); resetn = 1;
        m_st = S_TITLE; m_x = XST; m_req = 0; m_prev = 0;
        chk("d2_reset_x", bus2.rocket_x, 3);
        bus2.start = 1; cyc2(); bus2.start = 0; cyc2();
        chk("d2_clear", bus2.state_dbg, S_CLEAR);
        bus2.clear_done = 1; cyc2(); bus2.clear_done = 0;
        bus2.draw_done = 1; cyc2(); cyc2(); bus2.draw_done = 0;
        chk("d2_cmd", bus2.state_dbg, S_CMD);
        chk("d2_start_x", bus2.rocket_x, 3);
        x2 = 3;
        move2(0, x2); x2 = 0;
        move2(0, x2);
        for (int i = 0; i < 32; i++) begin
            move2(1, x2);
            x2 = (x2 + 5 > 152) ? 152 : x2 + 5;
        end
        move2(0, x2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
